// File: rtl/batamateur_pkg.sv
// Shared definitions for the microcoded controller and the uOP sequencer.
//   - FSM state encodings for the sequencer
//   - well-known microoperation indices
//   - instruction word field positions shared with the controller ROM,
//     plus a decode helper returning all fields at once
package batamateur_pkg;

  // Sequencer FSM state encoding
  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  // Well-known microoperation indices
  localparam logic [2:0] UOP_FETCH  = 3'd0;
  localparam logic [2:0] UOP_DECODE = 3'd1;
  localparam logic [2:0] UOP_IDLE   = 3'd7;

  // Instruction field positions (16-bit instruction word)
  localparam int unsigned INSTR_H_MSB = 15;
  localparam int unsigned INSTR_H_LSB = 12;
  localparam int unsigned INSTR_L_MSB = 11;
  localparam int unsigned INSTR_L_LSB = 7;
  localparam int unsigned ACC_SEL_BIT = 6;
  localparam int unsigned OP1_MSB     = 5;
  localparam int unsigned OP1_LSB     = 3;
  localparam int unsigned OP2_MSB     = 2;
  localparam int unsigned OP2_LSB     = 0;

  typedef struct packed {
    logic [3:0] instr_h;
    logic [4:0] instr_l;
    logic       acc_sel;
    logic [2:0] op1;
    logic [2:0] op2;
  } instr_fields_t;

  // Split an instruction word into the fields the controller decodes
  function automatic instr_fields_t decode_instr(input logic [15:0] i_word);
    instr_fields_t f;
    f.instr_h = i_word[INSTR_H_MSB:INSTR_H_LSB];
    f.instr_l = i_word[INSTR_L_MSB:INSTR_L_LSB];
    f.acc_sel = i_word[ACC_SEL_BIT];
    f.op1     = i_word[OP1_MSB:OP1_LSB];
    f.op2     = i_word[OP2_MSB:OP2_LSB];
    return f;
  endfunction

endpackage

// File: rtl/uop_counter.sv
// Microoperation counter for the uOP sequencer.
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset (counter resets to idle word)
//   i_force_idle park the counter at the idle word (all ones)
//   i_load_zero  restart at uOP 0 (first uOP of an instruction)
//   i_inc        advance by one, wrapping from all ones to 0
//   o_uop        registered counter value
// Control priority: force_idle > load_zero > inc > hold.
module uop_counter #(
  parameter int unsigned UOP_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_force_idle,
  input  logic                 i_load_zero,
  input  logic                 i_inc,
  output logic [UOP_WIDTH-1:0] o_uop
);

  logic [UOP_WIDTH-1:0] r_uop;

  // Counter register with prioritized idle / zero / increment controls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_uop <= {UOP_WIDTH{1'b1}};
    end else if (i_force_idle) begin
      r_uop <= {UOP_WIDTH{1'b1}};
    end else if (i_load_zero) begin
      r_uop <= {UOP_WIDTH{1'b0}};
    end else if (i_inc) begin
      r_uop <= r_uop + UOP_WIDTH'(1'b1);
    end else begin
      r_uop <= r_uop;
    end
  end

  assign o_uop = r_uop;

endmodule

// File: rtl/uop_sequencer.sv
// uOP sequencer: drives the microcoded controller ROM and consumes its
// sequencing outputs, with run/halt/single-step control for a debug panel.
// Ports:
//   CLK, RST_N   clock and asynchronous active-low reset
//   BUS_IN       shared data bus value (loaded into IR on IR_LOAD)
//   IR_LOAD      load IR from BUS_IN
//   IR_EN        drive IR operand field onto the bus
//   RESET_uOP    controller marks the last uOP of the instruction
//   READ_FLAGS   capture ALU_ZERO / ALU_COUT
//   HALT_REQ     level: park at the next instruction boundary
//   STEP_REQ     pulse: run one instruction while halted
//   INSTR, uOP   instruction register and uOP index fed back to controller
//   ZERO_FLAG, COUT_FLAG  latched ALU flags
//   IR_BUS_OUT, IR_BUS_OE combinational bus drive of the operand field
//   HALTED       parked in halt
//   STEP_ACK     one-cycle pulse after a single step completes
//   INSTR_COUNT  retired-instruction count (wraps)
module uop_sequencer
  import batamateur_pkg::*;
#(
  parameter int unsigned IR_WIDTH   = 16,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned UOP_WIDTH  = 3,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [IR_WIDTH-1:0]   BUS_IN,
  input  logic                  IR_LOAD,
  input  logic                  IR_EN,
  input  logic                  RESET_uOP,
  input  logic                  READ_FLAGS,
  input  logic                  ALU_ZERO,
  input  logic                  ALU_COUT,
  input  logic                  HALT_REQ,
  input  logic                  STEP_REQ,
  output logic [IR_WIDTH-1:0]   INSTR,
  output logic [UOP_WIDTH-1:0]  uOP,
  output logic                  ZERO_FLAG,
  output logic                  COUT_FLAG,
  output logic [IR_WIDTH-1:0]   IR_BUS_OUT,
  output logic                  IR_BUS_OE,
  output logic                  HALTED,
  output logic                  STEP_ACK,
  output logic [CNT_WIDTH-1:0]  INSTR_COUNT
);

  logic [1:0]           r_state;
  logic [IR_WIDTH-1:0]  r_instr;
  logic                 r_zero;
  logic                 r_cout;
  logic                 r_halted;
  logic                 r_step_ack;
  logic [CNT_WIDTH-1:0] r_count;

  logic [1:0]           w_state_nxt;
  logic                 w_force_idle;
  logic                 w_load_zero;
  logic                 w_inc;
  logic                 w_boundary;
  logic                 w_halted_nxt;
  logic                 w_ack_nxt;
  logic [UOP_WIDTH-1:0] w_uop;
  logic                 w_uop_last;

  uop_counter #(
    .UOP_WIDTH (UOP_WIDTH)
  ) u_uop_counter (
    .clk          (CLK),
    .rst_n        (RST_N),
    .i_force_idle (w_force_idle),
    .i_load_zero  (w_load_zero),
    .i_inc        (w_inc),
    .o_uop        (w_uop)
  );

  // A wrap from the last uOP back to 0 also ends an instruction
  assign w_uop_last = (w_uop == {UOP_WIDTH{1'b1}});

  // Next-state, counter controls, halted/ack next values
  always_comb begin
    w_state_nxt  = r_state;
    w_force_idle = 1'b0;
    w_load_zero  = 1'b0;
    w_inc        = 1'b0;
    w_boundary   = 1'b0;
    w_halted_nxt = r_halted;
    w_ack_nxt    = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (HALT_REQ) begin
          w_state_nxt  = ST_HALT;
          w_force_idle = 1'b1;
          w_halted_nxt = 1'b1;
        end else begin
          w_state_nxt  = ST_RUN;
          w_load_zero  = 1'b1;
          w_halted_nxt = 1'b0;
        end
      end
      ST_RUN: begin
        w_boundary = RESET_uOP | w_uop_last;
        // HALT_REQ is only honoured at a boundary so instructions complete
        if (w_boundary && HALT_REQ) begin
          w_state_nxt  = ST_HALT;
          w_force_idle = 1'b1;
          w_halted_nxt = 1'b1;
        end else if (RESET_uOP) begin
          w_load_zero = 1'b1;
        end else begin
          w_inc = 1'b1;
        end
      end
      ST_STEP: begin
        w_boundary = RESET_uOP | w_uop_last;
        // STEP_REQ is not looked at here: repeats during a step are dropped
        if (w_boundary) begin
          w_state_nxt  = ST_HALT;
          w_force_idle = 1'b1;
          w_halted_nxt = 1'b1;
          w_ack_nxt    = 1'b1;
        end else begin
          w_inc = 1'b1;
        end
      end
      ST_HALT: begin
        if (STEP_REQ) begin
          w_state_nxt  = ST_STEP;
          w_load_zero  = 1'b1;
          w_halted_nxt = 1'b0;
        end else if (!HALT_REQ) begin
          w_state_nxt  = ST_RUN;
          w_load_zero  = 1'b1;
          w_halted_nxt = 1'b0;
        end else begin
          w_force_idle = 1'b1;
          w_halted_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt  = ST_INIT;
        w_force_idle = 1'b1;
        w_halted_nxt = 1'b0;
      end
    endcase
  end

  // FSM state, halted indicator and step acknowledge pulse
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= ST_INIT;
      r_halted   <= 1'b0;
      r_step_ack <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_halted   <= w_halted_nxt;
      r_step_ack <= w_ack_nxt;
    end
  end

  // Retired-instruction counter, one increment per boundary
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_count <= {CNT_WIDTH{1'b0}};
    end else if (w_boundary) begin
      r_count <= r_count + CNT_WIDTH'(1'b1);
    end else begin
      r_count <= r_count;
    end
  end

  // Instruction register, loadable in any state
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_instr <= {IR_WIDTH{1'b0}};
    end else if (IR_LOAD) begin
      r_instr <= BUS_IN;
    end else begin
      r_instr <= r_instr;
    end
  end

  // ALU flag latches, held (including through halt) unless READ_FLAGS
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_zero <= 1'b0;
      r_cout <= 1'b0;
    end else if (READ_FLAGS) begin
      r_zero <= ALU_ZERO;
      r_cout <= ALU_COUT;
    end else begin
      r_zero <= r_zero;
      r_cout <= r_cout;
    end
  end

  assign INSTR       = r_instr;
  assign uOP         = w_uop;
  assign ZERO_FLAG   = r_zero;
  assign COUT_FLAG   = r_cout;
  assign HALTED      = r_halted;
  assign STEP_ACK    = r_step_ack;
  assign INSTR_COUNT = r_count;

  // Bus drive reads the current IR, so a simultaneous load shows the old value
  assign IR_BUS_OUT = {{(IR_WIDTH-ADDR_WIDTH){1'b0}}, r_instr[ADDR_WIDTH-1:0]};
  assign IR_BUS_OE  = IR_EN;

endmodule

// File: tb/tb_uop_sequencer.sv
// Directed self-checking bench for uop_sequencer.
module tb_uop_sequencer;
  import batamateur_pkg::*;

  logic        CLK;
  logic        RST_N;
  logic [15:0] BUS_IN;
  logic        IR_LOAD;
  logic        IR_EN;
  logic        RESET_uOP;
  logic        READ_FLAGS;
  logic        ALU_ZERO;
  logic        ALU_COUT;
  logic        HALT_REQ;
  logic        STEP_REQ;
  logic [15:0] INSTR;
  logic [2:0]  uOP;
  logic        ZERO_FLAG;
  logic        COUT_FLAG;
  logic [15:0] IR_BUS_OUT;
  logic        IR_BUS_OE;
  logic        HALTED;
  logic        STEP_ACK;
  logic [15:0] INSTR_COUNT;

  int n_checks = 0;
  int n_errors = 0;
  instr_fields_t f;

  uop_sequencer dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .BUS_IN      (BUS_IN),
    .IR_LOAD     (IR_LOAD),
    .IR_EN       (IR_EN),
    .RESET_uOP   (RESET_uOP),
    .READ_FLAGS  (READ_FLAGS),
    .ALU_ZERO    (ALU_ZERO),
    .ALU_COUT    (ALU_COUT),
    .HALT_REQ    (HALT_REQ),
    .STEP_REQ    (STEP_REQ),
    .INSTR       (INSTR),
    .uOP         (uOP),
    .ZERO_FLAG   (ZERO_FLAG),
    .COUT_FLAG   (COUT_FLAG),
    .IR_BUS_OUT  (IR_BUS_OUT),
    .IR_BUS_OE   (IR_BUS_OE),
    .HALTED      (HALTED),
    .STEP_ACK    (STEP_ACK),
    .INSTR_COUNT (INSTR_COUNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_seq(input string tag, input logic [2:0] e_uop, input logic e_halted,
                         input logic e_ack, input logic [15:0] e_cnt);
    chk({tag, "_uop"}, 32'(uOP), 32'(e_uop));
    chk({tag, "_halted"}, 32'(HALTED), 32'(e_halted));
    chk({tag, "_ack"}, 32'(STEP_ACK), 32'(e_ack));
    chk({tag, "_cnt"}, 32'(INSTR_COUNT), 32'(e_cnt));
  endtask

  initial begin
    RST_N = 1'b0; BUS_IN = 16'h0000; IR_LOAD = 1'b0; IR_EN = 1'b0;
    RESET_uOP = 1'b0; READ_FLAGS = 1'b0; ALU_ZERO = 1'b0; ALU_COUT = 1'b0;
    HALT_REQ = 1'b0; STEP_REQ = 1'b0;

    // Reset state
    #12;
    chk_seq("rst", UOP_IDLE, 1'b0, 1'b0, 16'd0);
    chk("rst_instr", 32'(INSTR), 32'h0);
    chk("rst_zf", 32'(ZERO_FLAG), 32'h0);
    chk("rst_cf", 32'(COUT_FLAG), 32'h0);
    chk("rst_oe0", 32'(IR_BUS_OE), 32'h0);
    IR_EN = 1'b1;
    #1;
    chk("rst_oe1", 32'(IR_BUS_OE), 32'h1);
    IR_EN = 1'b0;
    tick();
    RST_N = 1'b1;

    // Init word for one cycle, then 0,1,2,3
    chk_seq("init", UOP_IDLE, 1'b0, 1'b0, 16'd0);
    tick(); chk_seq("run0", UOP_FETCH, 1'b0, 1'b0, 16'd0);
    tick(); chk_seq("run1", UOP_DECODE, 1'b0, 1'b0, 16'd0);
    tick(); chk_seq("run2", 3'd2, 1'b0, 1'b0, 16'd0);
    tick(); chk_seq("run3", 3'd3, 1'b0, 1'b0, 16'd0);

    // End instruction at uOP 3 while loading IR with bus drive enabled
    RESET_uOP = 1'b1; IR_LOAD = 1'b1; BUS_IN = 16'h1ABC; IR_EN = 1'b1;
    #1;
    chk("ld_same_oe", 32'(IR_BUS_OE), 32'h1);
    chk("ld_same_bus_old", 32'(IR_BUS_OUT), 32'h0000);
    tick();
    chk_seq("rst_uop", UOP_FETCH, 1'b0, 1'b0, 16'd1);
    chk("ir_loaded", 32'(INSTR), 32'h1ABC);
    chk("ir_bus", 32'(IR_BUS_OUT), 32'h0ABC);
    chk("ir_oe", 32'(IR_BUS_OE), 32'h1);
    f = decode_instr(INSTR);
    chk("fld_h", 32'(f.instr_h), 32'h1);
    chk("fld_l", 32'(f.instr_l), 32'h15);
    chk("fld_acc", 32'(f.acc_sel), 32'h0);
    chk("fld_op1", 32'(f.op1), 32'h7);
    chk("fld_op2", 32'(f.op2), 32'h4);
    RESET_uOP = 1'b0; IR_LOAD = 1'b0; IR_EN = 1'b0; BUS_IN = 16'hFFFF;

    // Flag capture
    READ_FLAGS = 1'b1; ALU_ZERO = 1'b1; ALU_COUT = 1'b0;
    tick();
    chk_seq("flg_u1", UOP_DECODE, 1'b0, 1'b0, 16'd1);
    chk("flg_z", 32'(ZERO_FLAG), 32'h1);
    chk("flg_c", 32'(COUT_FLAG), 32'h0);
    READ_FLAGS = 1'b0; ALU_ZERO = 1'b0; ALU_COUT = 1'b1;

    // HALT_REQ mid-instruction at uOP 1; instruction ends at uOP 3
    HALT_REQ = 1'b1;
    tick(); chk_seq("hq_u2", 3'd2, 1'b0, 1'b0, 16'd1);
    chk("hold_z", 32'(ZERO_FLAG), 32'h1);
    chk("hold_c", 32'(COUT_FLAG), 32'h0);
    tick(); chk_seq("hq_u3", 3'd3, 1'b0, 1'b0, 16'd1);
    RESET_uOP = 1'b1;
    tick(); chk_seq("halt0", UOP_IDLE, 1'b1, 1'b0, 16'd2);
    RESET_uOP = 1'b0; ALU_ZERO = 1'b1; ALU_COUT = 1'b1;
    tick(); chk_seq("halt1", UOP_IDLE, 1'b1, 1'b0, 16'd2);
    chk("halt_z", 32'(ZERO_FLAG), 32'h1);
    chk("halt_c", 32'(COUT_FLAG), 32'h0);

    // Single step, with a repeated STEP_REQ during the step
    STEP_REQ = 1'b1;
    tick(); chk_seq("st0", UOP_FETCH, 1'b0, 1'b0, 16'd2);
    STEP_REQ = 1'b0;
    tick(); chk_seq("st1", UOP_DECODE, 1'b0, 1'b0, 16'd2);
    STEP_REQ = 1'b1;
    tick(); chk_seq("st2", 3'd2, 1'b0, 1'b0, 16'd2);
    STEP_REQ = 1'b0;
    tick(); chk_seq("st3", 3'd3, 1'b0, 1'b0, 16'd2);
    RESET_uOP = 1'b1;
    tick(); chk_seq("st_done", UOP_IDLE, 1'b1, 1'b1, 16'd3);
    RESET_uOP = 1'b0;
    tick(); chk_seq("st_after", UOP_IDLE, 1'b1, 1'b0, 16'd3);
    tick(); chk_seq("st_park", UOP_IDLE, 1'b1, 1'b0, 16'd3);
    chk("st_z", 32'(ZERO_FLAG), 32'h1);

    // Resume run and let uOP wrap 7 -> 0 as a boundary
    HALT_REQ = 1'b0;
    tick(); chk_seq("res0", UOP_FETCH, 1'b0, 1'b0, 16'd3);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("wrap_uop", 32'(uOP), 32'(i));
      chk("wrap_cnt", 32'(INSTR_COUNT), 32'd3);
    end
    tick(); chk_seq("wrap", UOP_FETCH, 1'b0, 1'b0, 16'd4);

    // Immediate boundary with halt requested
    HALT_REQ = 1'b1; RESET_uOP = 1'b1;
    tick(); chk_seq("halt2", UOP_IDLE, 1'b1, 1'b0, 16'd5);
    RESET_uOP = 1'b0;

    // Async reset mid-step at uOP 2
    STEP_REQ = 1'b1;
    tick(); chk_seq("s2_0", UOP_FETCH, 1'b0, 1'b0, 16'd5);
    STEP_REQ = 1'b0;
    tick();
    tick(); chk_seq("s2_2", 3'd2, 1'b0, 1'b0, 16'd5);
    #2;
    RST_N = 1'b0;
    #1;
    chk_seq("arst", UOP_IDLE, 1'b0, 1'b0, 16'd0);
    chk("arst_instr", 32'(INSTR), 32'h0);
    chk("arst_zf", 32'(ZERO_FLAG), 32'h0);
    chk("arst_cf", 32'(COUT_FLAG), 32'h0);
    HALT_REQ = 1'b0;
    #1;
    RST_N = 1'b1;
    chk_seq("init2", UOP_IDLE, 1'b0, 1'b0, 16'd0);
    tick(); chk_seq("init2_u0", UOP_FETCH, 1'b0, 1'b0, 16'd0);
    tick(); chk_seq("init2_u1", UOP_DECODE, 1'b0, 1'b0, 16'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
